// File: rtl/nrzi_rx_decoder.sv
// nrzi_rx_decoder: NRZI line receiver with sync hunt, bit destuffing and valid/ready byte output
module nrzi_rx_decoder #(
   parameter int          DATA_W    = 8,
   parameter int          STUFF_LEN = 6,
   parameter logic [7:0]  SYNC_PAT  = 8'b1000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bit_en,
   input  logic              line_in,
   input  logic              eop,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              rx_active,
   output logic              frame_done,
   output logic              frame_err
);
   localparam int CW = $clog2(STUFF_LEN + 2);
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   typedef enum logic {HUNT, RECV} state_t;
   state_t              state_q, state_d;
   logic                prev_lvl_q, prev_lvl_d;
   logic [CW-1:0]       ones_cnt_q, ones_cnt_d;
   logic [7:0]          history_q, history_d;
   logic [3:0]          hist_cnt_q, hist_cnt_d;
   logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]   byte_q, byte_d;
   logic                overflow_q, overflow_d;
   logic [DATA_W-1:0]   data_out_q, data_out_d;
   logic                data_valid_q, data_valid_d;
   logic                frame_done_q, frame_done_d;
   logic                frame_err_q, frame_err_d;
   logic                d;
   logic [7:0]          hist_upd;
   logic [CW-1:0]       ones_inc;
   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign rx_active  = (state_q == RECV);
   assign frame_done = frame_done_q;
   assign frame_err  = frame_err_q;
   // decode, sync hunt, destuff, byte assembly and handshake; sync only counts once eight real bits are in history
   always_comb begin
      d            = ~(line_in ^ prev_lvl_q);
      hist_upd     = {d, history_q[7:1]};
      ones_inc     = (ones_cnt_q == CW'(STUFF_LEN + 1)) ? ones_cnt_q : ones_cnt_q + 1'b1;
      state_d      = state_q;
      prev_lvl_d   = prev_lvl_q;
      ones_cnt_d   = ones_cnt_q;
      history_d    = history_q;
      hist_cnt_d   = hist_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      byte_d       = byte_q;
      overflow_d   = overflow_q;
      data_out_d   = data_out_q;
      data_valid_d = data_valid_q & ~data_ready;
      frame_done_d = 1'b0;
      frame_err_d  = 1'b0;
      if (bit_en) begin
         prev_lvl_d = line_in;
         ones_cnt_d = d ? ones_inc : '0;
         history_d  = hist_upd;
         hist_cnt_d = (hist_cnt_q == 4'd8) ? hist_cnt_q : hist_cnt_q + 4'd1;
         if (state_q == HUNT) begin
            if (hist_upd == SYNC_PAT && hist_cnt_q >= 4'd7) begin
               state_d    = RECV;
               bit_cnt_d  = '0;
               overflow_d = 1'b0;
            end
         end else if (eop) begin
            frame_done_d = 1'b1;
            frame_err_d  = (bit_cnt_q != '0) | overflow_q;
            state_d      = HUNT;
         end else if (ones_cnt_q == CW'(STUFF_LEN)) begin
            frame_done_d = d;
            frame_err_d  = d;
            state_d      = d ? HUNT : RECV;
         end else begin
            byte_d    = {d, byte_q[DATA_W-1:1]};
            bit_cnt_d = (bit_cnt_q == BW'(DATA_W - 1)) ? '0 : bit_cnt_q + 1'b1;
            if (bit_cnt_q == BW'(DATA_W - 1)) begin
               data_out_d   = (!data_valid_q || data_ready) ? byte_d : data_out_q;
               data_valid_d = (!data_valid_q || data_ready) ? 1'b1 : data_valid_d;
               overflow_d   = (data_valid_q && !data_ready) ? 1'b1 : overflow_q;
            end
         end
      end
   end
   // state registers with synchronous reset to the idle hunt condition
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= HUNT;
         prev_lvl_q   <= 1'b1;
         ones_cnt_q   <= '0;
         history_q    <= '0;
         hist_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         byte_q       <= '0;
         overflow_q   <= 1'b0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_lvl_q   <= prev_lvl_d;
         ones_cnt_q   <= ones_cnt_d;
         history_q    <= history_d;
         hist_cnt_q   <= hist_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         byte_q       <= byte_d;
         overflow_q   <= overflow_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
      end
   end
endmodule

// File: tb/tb_nrzi_rx_decoder.sv
// tb_nrzi_rx_decoder: directed and randomized frames against a byte-level expectation queue
module tb_nrzi_rx_decoder;
   logic       clk = 1'b0;
   logic       rst, bit_en, line_in, eop, data_ready;
   logic [7:0] data_out;
   logic       data_valid, rx_active, frame_done, frame_err;
   int         checks = 0;
   int         errors = 0;
   logic       lvl;
   int         run;
   logic [7:0] rxq[$];
   logic [1:0] fq[$];
   logic [7:0] expq[$];
   nrzi_rx_decoder dut (
      .clk(clk), .rst(rst), .bit_en(bit_en), .line_in(line_in), .eop(eop),
      .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
      .rx_active(rx_active), .frame_done(frame_done), .frame_err(frame_err)
   );
   always #5 clk = ~clk;
   // consumer and frame-status observer, sampled mid-cycle
   always @(negedge clk) begin
      if (data_valid && data_ready) rxq.push_back(data_out);
      if (frame_done) fq.push_back({rx_active, frame_err});
   end
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic strobe(input logic l, input logic e);
      repeat ($urandom_range(0, 2)) begin
         bit_en  = 1'b0;
         line_in = 1'($urandom);
         eop     = 1'($urandom);
         tick();
      end
      bit_en  = 1'b1;
      line_in = l;
      eop     = e;
      tick();
      bit_en  = 1'b0;
      eop     = 1'b0;
   endtask
   task automatic send_dec(input logic b, input logic e);
      lvl = b ? lvl : ~lvl;
      strobe(lvl, e);
      run = b ? run + 1 : 0;
   endtask
   task automatic send_data(input logic b);
      send_dec(b, 1'b0);
      if (b && run == 6) send_dec(1'b0, 1'b0);
   endtask
   task automatic send_sync();
      repeat (7) send_dec(1'b0, 1'b0);
      send_dec(1'b1, 1'b0);
   endtask
   task automatic send_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) send_data(b[i]);
   endtask
   task automatic idle(input int n);
      repeat (n) send_dec(1'b1, 1'b0);
   endtask
   task automatic do_reset();
      rst = 1'b1; bit_en = 1'b0; eop = 1'b0; line_in = 1'b1;
      repeat (2) tick();
      chk("rst_data_out", data_out, 0);
      chk("rst_data_valid", data_valid, 0);
      chk("rst_rx_active", rx_active, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_frame_err", frame_err, 0);
      rst = 1'b0; lvl = 1'b1; run = 0;
      rxq.delete(); fq.delete();
   endtask
   task automatic check_frame(input string tag, input logic exp_err);
      repeat (4) tick();
      chk({tag, "_nbytes"}, rxq.size(), expq.size());
      for (int i = 0; i < expq.size(); i++)
         if (i < rxq.size()) chk({tag, "_byte"}, rxq[i], expq[i]);
      chk({tag, "_npulses"}, fq.size(), 1);
      if (fq.size() > 0) begin
         chk({tag, "_err"}, fq[0][0], exp_err);
         chk({tag, "_rx_active"}, fq[0][1], 0);
      end
      chk({tag, "_active_after"}, rx_active, 0);
      rxq.delete(); fq.delete(); expq.delete();
   endtask
   initial begin
      data_ready = 1'b1;
      do_reset();
      idle(20);
      chk("idle_rx_active", rx_active, 0);
      chk("idle_data_valid", data_valid, 0);
      chk("idle_data_out", data_out, 0);
      chk("idle_pulses", fq.size(), 0);
      send_sync();
      for (int i = 0; i < 7; i++) send_data(1'(8'hA5 >> i));
      chk("a5_valid_early", data_valid, 0);
      send_data(1'b1);
      chk("a5_latency_valid", data_valid, 1);
      chk("a5_latency_data", data_out, 8'hA5);
      send_dec(1'b1, 1'b1);
      expq.push_back(8'hA5);
      check_frame("a5", 1'b0);
      idle(3);
      send_sync();
      send_byte(8'h01);
      send_byte(8'hFF);
      send_dec(1'b1, 1'b1);
      expq.push_back(8'h01); expq.push_back(8'hFF);
      check_frame("stuff", 1'b0);
      idle(3);
      send_sync();
      repeat (7) send_dec(1'b1, 1'b0);
      check_frame("stufferr", 1'b1);
      idle(3);
      data_ready = 1'b0;
      send_sync();
      send_byte(8'h12);
      send_byte(8'h34);
      send_dec(1'b1, 1'b1);
      repeat (4) tick();
      chk("ovf_nbytes", rxq.size(), 0);
      chk("ovf_valid", data_valid, 1);
      chk("ovf_data", data_out, 8'h12);
      chk("ovf_npulses", fq.size(), 1);
      if (fq.size() > 0) chk("ovf_err", fq[0][0], 1);
      fq.delete();
      data_ready = 1'b1;
      repeat (3) tick();
      chk("ovf_accept_n", rxq.size(), 1);
      if (rxq.size() > 0) chk("ovf_accept_data", rxq[0], 8'h12);
      chk("ovf_valid_after", data_valid, 0);
      rxq.delete();
      idle(3);
      send_sync();
      send_data(1'b1); send_data(1'b0); send_data(1'b1);
      do_reset();
      send_sync();
      send_byte(8'h3C);
      send_dec(1'b1, 1'b1);
      expq.push_back(8'h3C);
      check_frame("post_rst", 1'b0);
      for (int f = 0; f < 20; f++) begin
         int nb, k;
         logic [7:0] b;
         idle($urandom_range(1, 4));
         nb = $urandom_range(1, 4);
         k = (f % 3 == 0) ? $urandom_range(1, 7) : 0;
         send_sync();
         for (int j = 0; j < nb; j++) begin
            b = 8'($urandom);
            if (f % 4 == 1) b = 8'hFF;
            expq.push_back(b);
            send_byte(b);
         end
         for (int j = 0; j < k; j++) send_data(1'($urandom));
         send_dec(1'b1, 1'b1);
         check_frame("rand", k != 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
